uart_tx_scheduler: RTL and testbench
====================================

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 1, meaning clock cycles per serial bit; legal values are 1 to 255.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-004 SHALL have port req0, input, 1, requester 0 has a byte to send; held high until gnt0.
REQ-005 SHALL have port data0, input, 8, requester 0 byte; stable while req0 is high.
REQ-006 SHALL have port req1, input, 1, requester 1 request; same rules as req0.
REQ-007 SHALL have port data1, input, 8, requester 1 byte.
REQ-008 SHALL have port gnt0, output, 1, one-cycle pulse: data0 captured.
REQ-009 SHALL have port gnt1, output, 1, one-cycle pulse: data1 captured.
REQ-010 SHALL have port owner, output, 1, requester index of the frame in flight; holds its last value when idle.
REQ-011 SHALL have port busy, output, 1, high from the first start-bit cycle through the last stop-bit cycle.
REQ-012 SHALL have port serial_out, output, 1, UART line; idle level 1.
REQ-013 SHALL have port frame_done, output, 1, one-cycle pulse in the cycle after the last stop-bit cycle.

Function
REQ-014 SHALL implement the FSM states IDLE, START, DATA, STOP.
REQ-015 SHALL drive serial_out per state: IDLE 1, START 0, DATA shift_reg[0], STOP 1; all outputs registered.
REQ-016 SHALL hold every bit for exactly CLKS_PER_BIT cycles using a bit-time counter that restarts at each bit boundary.
REQ-017 SHALL send DATA LSB first, 8 bits, using a 3-bit bit index that wraps 7->0 on the exit to STOP.
REQ-018 SHALL give each frame a length of exactly 10*CLKS_PER_BIT cycles: 1 start, 8 data, 1 stop bit.
REQ-019 SHALL arbitrate on edges where the state is IDLE, or where it is the last cycle of STOP, and at least one req is high.
REQ-020 SHALL, when exactly one req is high, grant that requester.
REQ-021 SHALL, when both reqs are high, grant round-robin: the requester not in last_grant.
REQ-022 SHALL, on a grant edge: capture the winner's data into shift_reg; update last_grant and owner; pulse the matching gnt next cycle; enter START.
REQ-023 SHALL make the first start-bit cycle coincide with the gnt pulse cycle, giving a latency of 1 cycle from sampled req to line low.
REQ-024 SHALL, back-to-back, go STOP->START with no idle cycle if a req is pending at the last STOP cycle; frame_done and the new gnt then pulse in the same cycle.
REQ-025 SHALL ignore req and data changes during START and DATA, and during STOP before its last cycle; the captured byte is unaffected.
REQ-026 SHALL not capture a req that drops before being sampled at a grant edge, and SHALL not issue a gnt for it.
REQ-027 SHALL never assert gnt0 and gnt1 in the same cycle.
REQ-028 SHALL start at most one frame per grant; a requester that keeps req high after its gnt is treated as a new request.

Reset
REQ-029 SHALL, while rst is high, immediately force: state IDLE, serial_out 1, busy 0, gnt0/gnt1 0, frame_done 0, owner 0, last_grant 1 (so req0 wins first contention), counters 0, shift_reg 0x00.
REQ-030 SHALL, on rst asserted mid-frame, abort the frame with no frame_done; the line returns to 1 asynchronously.
REQ-031 SHALL, after rst deasserts, sample requests no earlier than the first following clock edge.

Verification
REQ-032 SHALL be verified for single send (CLKS_PER_BIT=1, req0=1, data0=0xA4): gnt0 pulses once; serial_out reads 0,0,0,1,0,0,1,0,1,1 on consecutive cycles; frame_done follows; busy high for 10 cycles.
REQ-033 SHALL be verified for contention (req0 and req1 both high from reset release, data0=0x55, data1=0x0F): frame 1 owner=0 carries 0x55; frame 2 starts the cycle after frame 1's stop with owner=1 carrying 0x0F; exactly one gnt per frame.
REQ-034 SHALL be verified for fairness (both reqs held for 4 frames): owner sequence 0,1,0,1; no idle cycles between frames.
REQ-035 SHALL be verified for bit timing (CLKS_PER_BIT=4, data1=0x80): each bit lasts 4 cycles; the frame lasts 40 cycles; only the 8th data bit is 1.
REQ-036 SHALL be verified for reset mid-frame (rst pulsed during data bit 3): serial_out goes 1 before the next edge, with no frame_done and no gnt; a pending req0 is granted on the first edge after release.
REQ-037 SHALL be verified for data change after grant (data0 changes 0x3C->0xFF in the cycle after gnt0): the line still carries 0x3C.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//   Two-requester UART transmitter. Round-robin arbitration between req0 and
//   req1, then one 8N1 frame (start, 8 data bits LSB first, stop) per grant.
//   Every bit is held for CLKS_PER_BIT clock cycles.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   req0/data0   requester 0 request and byte (held until gnt0)
//   req1/data1   requester 1 request and byte (held until gnt1)
//   gnt0/gnt1    one-cycle pulse: matching byte captured, first start-bit cycle
//   owner        requester index of the frame in flight (holds when idle)
//   busy         high from the first start-bit cycle through the last stop-bit cycle
//   serial_out   UART line, idle 1
//   frame_done   one-cycle pulse in the cycle after the last stop-bit cycle
module uart_tx_scheduler #(
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [7:0] data0,
    input  logic       req1,
    input  logic [7:0] data1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       owner,
    output logic       busy,
    output logic       serial_out,
    output logic       frame_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(CLKS_PER_BIT - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] shift_q, shift_d;
    logic       last_grant_q, last_grant_d;

    logic       owner_q, owner_d;
    logic       busy_q, busy_d;
    logic       serial_q, serial_d;
    logic       gnt0_q, gnt0_d;
    logic       gnt1_q, gnt1_d;
    logic       frame_done_q, frame_done_d;

    logic       bit_end;
    logic       arb_point;
    logic       grant;
    logic       winner;

    // Arbitration is allowed when idle and in the last STOP cycle, so a
    // pending request chains STOP->START with no idle gap.
    always_comb begin
        bit_end   = (cnt_q == LAST_CNT);
        arb_point = (state_q == IDLE) || ((state_q == STOP) && bit_end);
        grant     = arb_point && (req0 || req1);
        winner    = (req0 && req1) ? ~last_grant_q : req1;
    end

    // State register: all flops, including the registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            busy_q       <= 1'b0;
            serial_q     <= 1'b1;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            busy_q       <= busy_d;
            serial_q     <= serial_d;
            gnt0_q       <= gnt0_d;
            gnt1_q       <= gnt1_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        last_grant_d = last_grant_q;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    cnt_d     = '0;
                    bit_idx_d = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d     = '0;
                    bit_idx_d = bit_idx_q + 3'd1;
                    shift_d   = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // grant can only be true in IDLE or the last STOP cycle, so it
        // overrides the idle transition above in both places.
        if (grant) begin
            state_d      = START;
            cnt_d        = '0;
            shift_d      = winner ? data1 : data0;
            last_grant_d = winner;
        end
    end

    // Output logic: computed from the next state so the registered outputs
    // line up with the state they describe.
    always_comb begin
        gnt0_d       = grant && !winner;
        gnt1_d       = grant && winner;
        owner_d      = grant ? winner : owner_q;
        frame_done_d = (state_q == STOP) && bit_end;
        busy_d       = (state_d != IDLE);
        serial_d     = 1'b1;
        unique case (state_d)
            IDLE:    serial_d = 1'b1;
            START:   serial_d = 1'b0;
            DATA:    serial_d = shift_d[0];
            STOP:    serial_d = 1'b1;
            default: serial_d = 1'b1;
        endcase
    end

    assign gnt0       = gnt0_q;
    assign gnt1       = gnt1_q;
    assign owner      = owner_q;
    assign busy       = busy_q;
    assign serial_out = serial_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Testbench for uart_tx_scheduler: two instances (CLKS_PER_BIT 1 and 4)
// sharing clock and reset; expected frames are queued as requests are raised
// and compared sample by sample as the line produces them.
module tb_uart_tx_scheduler;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       req0_a, req1_a, gnt0_a, gnt1_a, owner_a, busy_a, so_a, fd_a;
    logic [7:0] data0_a, data1_a;
    logic       req0_b, req1_b, gnt0_b, gnt1_b, owner_b, busy_b, so_b, fd_b;
    logic [7:0] data0_b, data1_b;

    uart_tx_scheduler #(.CLKS_PER_BIT(1)) dut_a (
        .clk(clk), .rst(rst),
        .req0(req0_a), .data0(data0_a), .req1(req1_a), .data1(data1_a),
        .gnt0(gnt0_a), .gnt1(gnt1_a), .owner(owner_a), .busy(busy_a),
        .serial_out(so_a), .frame_done(fd_a)
    );

    uart_tx_scheduler #(.CLKS_PER_BIT(4)) dut_b (
        .clk(clk), .rst(rst),
        .req0(req0_b), .data0(data0_b), .req1(req1_b), .data1(data1_b),
        .gnt0(gnt0_b), .gnt1(gnt1_b), .owner(owner_b), .busy(busy_b),
        .serial_out(so_b), .frame_done(fd_b)
    );

    typedef struct {
        logic       owner;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
        end
    endtask

    logic s_g0, s_g1, s_so, s_bz, s_fd, s_ow;

    task automatic sample(input int inst);
        if (inst == 0) begin
            s_g0 = gnt0_a; s_g1 = gnt1_a; s_so = so_a;
            s_bz = busy_a; s_fd = fd_a;   s_ow = owner_a;
        end else begin
            s_g0 = gnt0_b; s_g1 = gnt1_b; s_so = so_b;
            s_bz = busy_b; s_fd = fd_b;   s_ow = owner_b;
        end
    endtask

    task automatic drop_req(input int inst, input logic who);
        if (inst == 0) begin
            if (who) req1_a = 1'b0; else req0_a = 1'b0;
        end else begin
            if (who) req1_b = 1'b0; else req0_b = 1'b0;
        end
    endtask

    // Called positioned at a negedge. Waits for each grant, then checks every
    // cycle of the frame against the queued expectation.
    task automatic collect(input int inst, input int nframes, input bit chk_lat, input bit chg_data);
        int   cpb;
        int   waited;
        int   pending;
        int   b;
        logic wantbit;
        exp_t e;
        cpb = (inst == 0) ? 1 : 4;
        for (int f = 0; f < nframes; f++) begin
            waited = 0;
            sample(inst);
            while (!(s_g0 | s_g1) && waited < 20) begin
                @(negedge clk);
                waited++;
                sample(inst);
            end
            if (!(s_g0 | s_g1)) begin
                check_val("gnt_timeout", 32'd0, 32'd1);
                return;
            end
            if (sb.size() == 0) begin
                check_val("sb_empty", 32'd0, 32'd1);
                return;
            end
            e = sb.pop_front();
            check_val("gnt_excl", 32'(s_g0 & s_g1), 32'd0);
            check_val("gnt_who", 32'(s_g1), 32'(e.owner));
            check_val("owner", 32'(s_ow), 32'(e.owner));
            if (f > 0) check_val("idle_gap", 32'(waited), 32'd0);
            else if (chk_lat) check_val("latency", 32'(waited), 32'd1);
            if (f == 0 && waited > 0) check_val("fd_at_start", 32'(s_fd), 32'd0);

            pending = 0;
            foreach (sb[k]) if (sb[k].owner == e.owner) pending++;
            if (pending == 0) drop_req(inst, e.owner);

            for (int i = 0; i < 10 * cpb; i++) begin
                if (i > 0) begin
                    @(negedge clk);
                    sample(inst);
                    check_val("gnt_extra", 32'(s_g0 | s_g1), 32'd0);
                    check_val("fd_early", 32'(s_fd), 32'd0);
                end
                if (chg_data && i == 1 && inst == 0) data0_a = 8'hFF;
                b = i / cpb;
                if (b == 0)      wantbit = 1'b0;
                else if (b == 9) wantbit = 1'b1;
                else             wantbit = e.data[b-1];
                check_val("line", 32'(s_so), 32'(wantbit));
                check_val("busy", 32'(s_bz), 32'd1);
                check_val("owner_hold", 32'(s_ow), 32'(e.owner));
            end
            @(negedge clk);
            sample(inst);
            check_val("frame_done", 32'(s_fd), 32'd1);
            if (sb.size() == 0) check_val("busy_end", 32'(s_bz), 32'd0);
        end
    endtask

    task automatic no_dup_gnt(input int inst);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            sample(inst);
            check_val("gnt_dup", 32'(s_g0 | s_g1), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req0_a = 1'b0; req1_a = 1'b0; data0_a = '0; data1_a = '0;
        req0_b = 1'b0; req1_b = 1'b0; data0_b = '0; data1_b = '0;
        @(negedge clk);
        @(negedge clk);

        // Reset state on both instances.
        for (int inst = 0; inst < 2; inst++) begin
            sample(inst);
            check_val("rst_line", 32'(s_so), 32'd1);
            check_val("rst_busy", 32'(s_bz), 32'd0);
            check_val("rst_gnt", 32'(s_g0 | s_g1), 32'd0);
            check_val("rst_fd", 32'(s_fd), 32'd0);
            check_val("rst_owner", 32'(s_ow), 32'd0);
        end

        // Contention from reset release: req0 wins first, req1 chains on.
        data0_a = 8'h55; data1_a = 8'h0F;
        req0_a = 1'b1;   req1_a = 1'b1;
        sb.push_back('{owner: 1'b0, data: 8'h55});
        sb.push_back('{owner: 1'b1, data: 8'h0F});
        rst = 1'b0;
        collect(0, 2, 1'b1, 1'b0);

        // Fairness: both held for four frames, alternating owners.
        data0_a = 8'h96; data1_a = 8'h3A;
        req0_a = 1'b1;   req1_a = 1'b1;
        sb.push_back('{owner: 1'b0, data: 8'h96});
        sb.push_back('{owner: 1'b1, data: 8'h3A});
        sb.push_back('{owner: 1'b0, data: 8'h96});
        sb.push_back('{owner: 1'b1, data: 8'h3A});
        collect(0, 4, 1'b0, 1'b0);

        // Single send.
        data0_a = 8'hA4; req0_a = 1'b1;
        sb.push_back('{owner: 1'b0, data: 8'hA4});
        collect(0, 1, 1'b1, 1'b0);
        no_dup_gnt(0);

        // Bit timing with 4 clocks per bit.
        data1_b = 8'h80; req1_b = 1'b1;
        sb.push_back('{owner: 1'b1, data: 8'h80});
        collect(1, 1, 1'b1, 1'b0);
        no_dup_gnt(1);

        // Reset during data bit 3 with req0 still pending.
        data0_a = 8'hA5; req0_a = 1'b1;
        @(negedge clk);
        check_val("pre_rst_gnt", 32'(gnt0_a), 32'd1);
        repeat (4) @(negedge clk);
        check_val("pre_rst_line", 32'(so_a), 32'd0);
        check_val("pre_rst_busy", 32'(busy_a), 32'd1);
        #1 rst = 1'b1;
        #1;
        check_val("async_line", 32'(so_a), 32'd1);
        check_val("async_busy", 32'(busy_a), 32'd0);
        check_val("async_gnt", 32'(gnt0_a | gnt1_a), 32'd0);
        check_val("async_fd", 32'(fd_a), 32'd0);
        check_val("async_owner", 32'(owner_a), 32'd0);
        data0_a = 8'h3C;
        @(negedge clk);
        check_val("in_rst_fd", 32'(fd_a), 32'd0);
        check_val("in_rst_line", 32'(so_a), 32'd1);
        check_val("in_rst_gnt", 32'(gnt0_a | gnt1_a), 32'd0);
        rst = 1'b0;
        // Post-release frame also covers a data change right after the grant.
        sb.push_back('{owner: 1'b0, data: 8'h3C});
        collect(0, 1, 1'b1, 1'b1);
        check_val("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
